// File: rtl/instdecoder_pkg.sv
// instdecoder_pkg: opcode, mode and microcode address constants plus the decode result type
package instdecoder_pkg;
    localparam int UC_W = 5;
    localparam logic [5:0] OPC_ALU_A = 6'b001100;
    localparam logic [5:0] OPC_ALU_B = 6'b010100;
    localparam logic [5:0] OPC_ALU_C = 6'b011100;
    localparam logic [5:0] OPC_01 = 6'b000001;
    localparam logic [5:0] OPC_02 = 6'b000010;
    localparam logic [5:0] OPC_03 = 6'b000011;
    localparam logic [5:0] OPC_05 = 6'b000101;
    localparam logic [5:0] OPC_06 = 6'b000110;
    localparam logic [5:0] OPC_0E = 6'b001110;
    localparam logic [1:0] MD_00 = 2'b00;
    localparam logic [1:0] MD_01 = 2'b01;
    localparam logic [1:0] MD_10 = 2'b10;
    localparam logic [UC_W-1:0] UC_0 = 5'd0;
    localparam logic [UC_W-1:0] UC_1 = 5'd1;
    localparam logic [UC_W-1:0] UC_5 = 5'd5;
    localparam logic [UC_W-1:0] UC_9 = 5'd9;
    localparam logic [UC_W-1:0] UC_10 = 5'd10;
    localparam logic [UC_W-1:0] UC_11 = 5'd11;
    localparam logic [UC_W-1:0] UC_12 = 5'd12;
    localparam logic [UC_W-1:0] UC_14 = 5'd14;
    localparam logic [UC_W-1:0] UC_15 = 5'd15;
    localparam logic [UC_W-1:0] UC_16 = 5'd16;
    localparam logic [UC_W-1:0] UC_17 = 5'd17;
    localparam logic [UC_W-1:0] UC_19 = 5'd19;
    localparam logic [UC_W-1:0] UC_21 = 5'd21;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef struct packed {
        logic [UC_W-1:0] ib;
        logic [UC_W-1:0] sb;
        logic [2:0]      op_s;
        logic            illegal;
    } dec_t;

    localparam dec_t DEC_ILLEGAL = dec_t'{ib: '1, sb: '1, op_s: OP_ILLEGAL, illegal: 1'b1};

    function automatic dec_t md_dec(input logic [1:0] md, input logic [UC_W-1:0] ib0,
                                    input logic [UC_W-1:0] sub, input logic has0);
        return md == MD_00 ? (has0 ? dec_t'{ib: ib0, sb: UC_0, op_s: 3'd0, illegal: 1'b0} : DEC_ILLEGAL) :
               md == MD_01 ? dec_t'{ib: UC_5, sb: sub, op_s: 3'd0, illegal: 1'b0} :
               md == MD_10 ? dec_t'{ib: UC_1, sb: sub, op_s: 3'd0, illegal: 1'b0} : DEC_ILLEGAL;
    endfunction
endpackage

// File: rtl/instdecode_core.sv
// instdecode_core: combinational instruction word to microcode entry decode table
module instdecode_core
    import instdecoder_pkg::*;
(
    input  logic [15:0] instcode,
    output dec_t        dec
);
    logic [5:0] opc;
    logic [1:0] md;
    logic       unused_bits;
    dec_t       t;
    assign opc = instcode[15:10];
    assign md = instcode[5:4];
    assign unused_bits = ^{instcode[9:6], instcode[3:0]};
    always_comb begin
        t = DEC_ILLEGAL;
        case (opc)
            OPC_ALU_A, OPC_ALU_B, OPC_ALU_C: t = md_dec(md, UC_17, UC_12, 1'b1);
            OPC_01: t = md_dec(md, UC_15, UC_10, 1'b1);
            OPC_02: t = md_dec(md, UC_16, UC_11, 1'b1);
            OPC_03: t = md_dec(md, UC_0, UC_14, 1'b0);
            OPC_05: t = dec_t'{ib: UC_9, sb: UC_0, op_s: 3'd0, illegal: 1'b0};
            OPC_06: t = dec_t'{ib: UC_19, sb: UC_0, op_s: 3'd0, illegal: 1'b0};
            OPC_0E: t = dec_t'{ib: UC_21, sb: UC_0, op_s: 3'd0, illegal: 1'b0};
            default: t = DEC_ILLEGAL;
        endcase
    end
    assign dec = t.illegal ? DEC_ILLEGAL : dec_t'{ib: t.ib, sb: t.sb, op_s: instcode[15:13], illegal: 1'b0};
endmodule

// File: rtl/instdecoder_pipe.sv
// instdecoder_pipe: decoder feeding a DEPTH-entry output FIFO; DEC_TRAP_EN adds a sticky illegal trap
module instdecoder_pipe
    import instdecoder_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] ib,
    output logic [ADDR_W-1:0] sb,
    output logic [2:0]        op_s,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt,
    output logic              trap,
    output logic [15:0]       trap_inst,
    input  logic              trap_clr
);
    localparam int AW = $clog2(DEPTH);
    dec_t       dec, head;
    dec_t       mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic       full, push, pop, stall;
    instdecode_core u_core (.instcode(instcode), .dec(dec));
    assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign out_valid = wptr != rptr;
    assign in_ready = !full && !flush && !stall;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign head = mem[rptr[AW-1:0]];
    assign ib = (!out_valid || head.illegal) ? '1 : ADDR_W'(head.ib);
    assign sb = (!out_valid || head.illegal) ? '1 : ADDR_W'(head.sb);
    assign op_s = out_valid ? head.op_s : OP_ILLEGAL;
    assign out_illegal = out_valid && head.illegal;
    always_ff @(posedge clk)
        if (push) mem[wptr[AW-1:0]] <= dec;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            illegal_cnt <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(push);
            rptr <= flush ? wptr : rptr + (AW+1)'(pop);
            if (push && dec.illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
`ifdef DEC_TRAP_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            trap <= 1'b0;
            trap_inst <= '0;
        end else if (push && dec.illegal) begin
            trap <= 1'b1;
            trap_inst <= instcode;
        end else if (trap_clr) trap <= 1'b0;
    assign stall = trap;
`else
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
    assign trap = 1'b0;
    assign trap_inst = '0;
    assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_instdecoder_pipe.sv
// tb_instdecoder_pipe: scoreboard bench with a table-level decode model and randomized traffic
module tb_instdecoder_pipe;
    localparam int ADDR_W = 5, DEPTH = 2, CNT_W = 3;
    localparam int ALL = (1 << ADDR_W) - 1;
    localparam int CMAX = (1 << CNT_W) - 1;
`ifdef DEC_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, trap_clr = 1'b0;
    logic in_ready, out_valid, out_illegal, trap;
    logic [15:0] instcode = '0, trap_inst;
    logic [ADDR_W-1:0] ib, sb;
    logic [2:0] op_s;
    logic [CNT_W-1:0] illegal_cnt;
    typedef struct {int ib; int sb; int op; int ill;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, exp_cnt = 0, exp_trap = 0, exp_tinst = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    instdecoder_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instcode(instcode), .out_valid(out_valid), .out_ready(out_ready), .ib(ib), .sb(sb),
        .op_s(op_s), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt), .trap(trap),
        .trap_inst(trap_inst), .trap_clr(trap_clr));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [15:0] c);
        int opc = int'(c[15:10]), md = int'(c[5:4]), op = int'(c[15:13]);
        int b0 = -1, sub = -1, fixed = -1;
        exp_t r = '{ALL, ALL, 7, 1};
        case (opc)
            12, 20, 28: begin b0 = 17; sub = 12; end
            1: begin b0 = 15; sub = 10; end
            2: begin b0 = 16; sub = 11; end
            3: sub = 14;
            5: fixed = 9;
            6: fixed = 19;
            14: fixed = 21;
            default: ;
        endcase
        if (fixed >= 0) r = '{fixed, 0, op, 0};
        else if (sub >= 0) begin
            if (md == 0 && b0 >= 0) r = '{b0, 0, op, 0};
            else if (md == 1) r = '{5, sub, op, 0};
            else if (md == 2) r = '{1, sub, op, 0};
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_code();
        int opcs[10] = '{12, 20, 28, 1, 2, 3, 5, 6, 14, 0};
        logic [15:0] c = 16'($urandom);
        if ($urandom_range(0, 3) != 0) c[15:10] = 6'(opcs[$urandom_range(0, 9)]);
        return c;
    endfunction

    // Monitor: checks the visible head and flags every cycle, retires entries on pop.
    always @(negedge clk) if (mon_en) begin
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < DEPTH && !flush && exp_trap == 0);
        chk("illegal_cnt", illegal_cnt, exp_cnt);
        chk("trap", trap, exp_trap);
        chk("trap_inst", trap_inst, exp_tinst);
        if (q.size() != 0) begin
            chk("ib", ib, q[0].ib);
            chk("sb", sb, q[0].sb);
            chk("op_s", op_s, q[0].op);
            chk("out_illegal", out_illegal, q[0].ill);
            if (out_ready) void'(q.pop_front());
        end else begin
            chk("ib_empty", ib, ALL);
            chk("op_s_empty", op_s, 7);
        end
        if (flush) q.delete();
    end

    task automatic step(input bit v, input logic [15:0] c, input bit rdy, input bit fl, input bit clr);
        bit acc;
        exp_t e;
        in_valid = v; instcode = c; out_ready = rdy; flush = fl; trap_clr = clr;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        e = ref_dec(c);
        if (acc) begin
            q.push_back(e);
            if (e.ill != 0 && exp_cnt < CMAX) exp_cnt++;
        end
        if (TRAP && acc && e.ill != 0) begin
            exp_trap = 1;
            exp_tinst = int'(c);
        end else if (TRAP && clr) exp_trap = 0;
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        in_valid = 1'b0; flush = 1'b0; trap_clr = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ib", ib, ALL);
        chk("rst_sb", sb, ALL);
        chk("rst_op_s", op_s, 7);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_illegal_cnt", illegal_cnt, 0);
        chk("rst_trap", trap, 0);
        chk("rst_trap_inst", trap_inst, 0);
        q.delete();
        exp_cnt = 0; exp_trap = 0; exp_tinst = 0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1 mon_en = 1'b1;
    endtask

    initial begin
        @(posedge clk) #1;
        do_reset();
        step(1, 16'h3010, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(1, 16'h0400, 1, 0, 0);
        step(1, 16'h1400, 1, 0, 0);
        step(1, 16'h7020, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(1, 16'h0C00, 1, 0, 0);
        step(1, 16'h3030, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 1);
        step(1, 16'h3030, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 16'h0C00, 1, 0, 1);
        step(0, 16'h0000, 1, 0, 1);
        step(1, 16'h3010, 0, 0, 0);
        step(1, 16'h0400, 0, 0, 0);
        step(1, 16'h1400, 0, 0, 0);
        step(1, 16'h1400, 1, 0, 0);
        step(0, 16'h0000, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(1, 16'h3010, 0, 0, 0);
        step(1, 16'h0400, 0, 0, 0);
        step(1, 16'h1400, 1, 1, 0);
        step(1, 16'h1800, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(1, 16'h0C00, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            step($urandom_range(0, 3) != 0, rand_code(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
        end
        step(0, 16'h0000, 1, 0, 1);
        step(0, 16'h0000, 1, 0, 1);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instdecoder_pipe.md
Name: instdecoder_pipe

Overview:
- Registered, flow-controlled successor to the combinational instruction decoder.
- Accepts 16-bit instruction words over a valid/ready handshake, decodes each into microcode entry addresses (ib, sb) and an op select, and queues results in a DEPTH-entry output FIFO.
- Counts illegal encodings. Sits between instruction fetch and the microcode sequencer.

Parameters:
- ADDR_W, 5: width of ib/sb; must be ≥5; table values zero-extended.
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- CNT_W, 8: illegal-instruction counter width; counter saturates.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous; empties FIFO.
- in_valid  in  1  instruction word present.
- in_ready  out  1  block accepts this cycle.
- instcode  in  16  instruction word.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- ib  out  ADDR_W  head microcode entry address.
- sb  out  ADDR_W  head sub-branch address.
- op_s  out  3  head op select.
- out_illegal  out  1  head entry was illegal.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal words.
- trap  out  1  sticky illegal trap (tied 0 unless DEC_TRAP_EN).
- trap_inst  out  16  instruction that raised trap (0 unless DEC_TRAP_EN).
- trap_clr  in  1  clears trap (ignored unless DEC_TRAP_EN).

Behaviour:
- Reset is asynchronous, active-high; single clock domain.
  - Reset values: FIFO empty, out_valid=0, ib/sb all-ones, op_s=7, out_illegal=0, illegal_cnt=0, trap=0, trap_inst=0.
- Decode fields: opc = instcode[15:10], md = instcode[5:4]. Legal op_s = instcode[15:13].
  - opc ∈ {001100, 010100, 011100}: md00 → ib17/sb0; md01 → 5/12; md10 → 1/12.
  - 000001: md00 → 15/0; md01 → 5/10; md10 → 1/10.
  - 000010: md00 → 16/0; md01 → 5/11; md10 → 1/11.
  - 000101 → 9/0; 000110 → 19/0; 001110 → 21/0 (md ignored).
  - 000011: md01 → 5/14; md10 → 1/14.
  - Everything else, including md=11 on the md-qualified opcodes and 000011 md00: illegal → ib/sb all-ones, op_s=7, out_illegal=1.
- Handshake:
  - Accept when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = !full && !flush (&& !trap when DEC_TRAP_EN).
  - Combinational ready path from out_ready to in_ready is forbidden; a full FIFO blocks input even if a pop occurs.
- Latency: accepted word appears at head the next cycle when the FIFO is empty. Head outputs are stable while out_valid && !out_ready.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged, order is preserved.
- Pointer wrap-around: modulo DEPTH; full/empty distinguished by an extra pointer bit.
- flush: next cycle, FIFO empty and out_valid=0. Pop in the flush cycle is still a valid transfer. illegal_cnt is not cleared.
- illegal_cnt: +1 per accepted illegal word; holds at 2^CNT_W−1.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.

Optional Feature:
- Macro: DEC_TRAP_EN.
- Defined:
  - An accepted illegal word sets trap=1 and captures trap_inst the next cycle.
  - The illegal entry is still enqueued.
  - While trap=1, in_ready=0 and the FIFO drains normally.
  - trap_clr clears trap the next cycle. If trap_clr coincides with a new illegal accept, set wins (impossible while trapped, since in_ready=0).
- Undefined: trap=0, trap_inst=0, trap_clr unused; no stall.

Decomposition:
- Package instdecoder_pkg holds:
  - opcode constants (OPC_ALU_A/B/C, OPC_01, OPC_02, OPC_03, OPC_05, OPC_06, OPC_0E);
  - mode constants;
  - microcode address constants (17, 5, 1, 15, 16, 9, 19, 21, 12, 10, 11, 14);
  - OP_ILLEGAL=7;
  - a decode result struct {ib, sb, op_s, illegal}.
- One sub-module: instdecode_core, purely combinational table, instantiated ahead of the FIFO write port.

Test Plan:
- Reset, then push 0x3010 → next cycle out_valid=1, ib=5, sb=12, op_s=1, out_illegal=0.
- Push 0x0400, 0x1400, 0x7020 back-to-back with out_ready=1 → heads, one per cycle, in order: (15,0,0), (9,0,0), (1,12,3).
- Push 0x0C00 and 0x3030 → both ib=sb=31, op_s=7, out_illegal=1; illegal_cnt=2. With CNT_W=2, five illegal pushes hold the count at 3.
- out_ready=0 with DEPTH=2: two pushes accepted, then in_ready=0; head stays 0x3010's decode; pulse out_ready and in_ready returns the following cycle.
- FIFO holding 2 entries, assert flush with in_valid=1 → input not accepted, next cycle out_valid=0; a following push emerges after 1 cycle.
- DEC_TRAP_EN: push 0x0C00 → trap=1, trap_inst=0x0C00, in_ready=0 until trap_clr; assert rst mid-trap → trap=0 asynchronously.
